retry_ctrl: RTL and testbench
=============================

// Module: retry_ctrl
// PURPOSE
//  Sequences one downstream request with timeout, back-off and bounded retry.
//  Issues req via valid/ready, waits for resp (ok/nack) within TIMEOUT cycles.
//  On nack/timeout: back off BACKOFF cycles, reissue, up to MAX_RETRY retries.
//  Reports a one-cycle done pulse plus final status. Sits between the NPU
//  command issuer and any slave port that can nack or stall.
// PARAMETERS
//  TIMEOUT    100  WAIT-cycle index at which a missing response is a timeout
//  BACKOFF    16   BACKOFF-cycle index at which the request is reissued
//  MAX_RETRY  3    reissues allowed after the first attempt (>=0)
//  RC_W       $clog2(MAX_RETRY+1) (min 1)  width of retry_cnt (localparam)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  start      in   1     begin a transaction; sampled only in IDLE
//  abort      in   1     cancel current transaction; ignored in IDLE
//  busy       out  1     high in every state except IDLE
//  req_valid  out  1     request to downstream; high only in ISSUE
//  req_ready  in   1     downstream accepts request
//  resp_valid in   1     downstream response strobe; sampled only in WAIT
//  resp_ok    in   1     qualifies resp_valid: 1=ok, 0=nack
//  done       out  1     one-cycle pulse, transaction finished
//  success    out  1     final status; valid from done, held until next start
//  timeout_evt out 1     one-cycle pulse on each timeout
//  retry_cnt  out  RC_W  retries performed; held until next start
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timer=0. Reset mid-transaction drops it, no done.
//  States: IDLE, ISSUE, WAIT, BACKOFF, DONE (registered Moore outputs).
//  IDLE: start=1 -> ISSUE next cycle; retry_cnt<=0, success<=0.
//  ISSUE: req_valid=1, held until req_ready; no timeout here.
//   Handshake cycle -> WAIT, timer cleared.
//  WAIT: timer = WAIT-cycle index (0,1,..), saturates at TIMEOUT.
//   resp_valid&resp_ok -> DONE, success<=1.
//   resp_valid&!resp_ok (nack), or timer==TIMEOUT with no resp (timeout_evt=1)
//   -> fail. Response on the timeout cycle wins (no timeout).
//  Fail: retry_cnt==MAX_RETRY -> DONE, success=0; else retry_cnt++, BACKOFF.
//  BACKOFF: timer cleared on entry; at timer==BACKOFF -> ISSUE (BACKOFF+1 cycles).
//  DONE: done=1 for exactly one cycle -> IDLE. start in DONE is ignored.
//  abort in ISSUE/WAIT/BACKOFF -> DONE next cycle, success=0; beats resp and
//   timeout in the same cycle; req_valid drops immediately.
//  start while busy is ignored. resp_valid outside WAIT is ignored.
//  retry_cnt never wraps: bounded by MAX_RETRY.
// STRUCTURE
//  retry_pkg: state encoding localparams, default TIMEOUT/BACKOFF/MAX_RETRY.
//  Sub-module retry_timer: saturating up-counter with clear/enable and an
//   at-limit flag; width $clog2(max(TIMEOUT,BACKOFF))+1. One instance, shared
//   by WAIT and BACKOFF; limit muxed by state, cleared on every state entry.
// TESTING (TIMEOUT=8, BACKOFF=4, MAX_RETRY=2)
//  1 start, req_ready=1, ok on WAIT idx 3 -> done 1 cycle later, success=1, retry_cnt=0
//  2 never respond -> 3 handshakes, 3 timeout_evt, each WAIT 9 cycles, BACKOFF 5;
//    done, success=0, retry_cnt=2
//  3 nack on first attempt, ok on second -> retry_cnt=1, success=1, 2 handshakes
//  4 ok on WAIT idx 8 (timeout cycle) -> success=1, timeout_evt never asserted
//  5 req_ready low 20 cycles -> req_valid held, no timeout; abort in BACKOFF ->
//    done next cycle, success=0
//  6 start while busy ignored; rst_n low mid-WAIT -> all outputs 0 at once,
//    no done; new start runs clean

Source files
------------

// File: rtl/retry_pkg.sv
// Shared types and defaults for the retry controller: state encoding,
// default timing parameters and width helpers.
package retry_pkg;

   localparam int DEF_TIMEOUT   = 100;
   localparam int DEF_BACKOFF   = 16;
   localparam int DEF_MAX_RETRY = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Width of the retry counter: enough to hold MAX_RETRY, never below one bit.
   function automatic int rcWidth(input int maxRetry);
      int w;
      w = $clog2(maxRetry + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Width of the shared timer: must be able to reach the larger of both limits.
   function automatic int timerWidth(input int timeoutLim, input int backoffLim);
      int biggest;
      biggest = (timeoutLim > backoffLim) ? timeoutLim : backoffLim;
      return $clog2(biggest) + 1;
   endfunction

endpackage

// File: rtl/retry_timer.sv
// Saturating up-counter with synchronous clear and enable; flags when the
// count equals the currently selected limit.
module retry_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         enable_i,
   input  logic [W-1:0] limit_i,
   output logic         atLimit_o
);

   logic [W-1:0] count_q;

   // Clear has priority so a fresh state always starts counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q < limit_i)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign atLimit_o = (count_q == limit_i);

endmodule

// File: rtl/retry_ctrl.sv
// Sequences one downstream request with response timeout, back-off and a
// bounded number of reissues; reports a done pulse with final status.
module retry_ctrl
   import retry_pkg::*;
#(
   parameter  int TIMEOUT   = DEF_TIMEOUT,
   parameter  int BACKOFF   = DEF_BACKOFF,
   parameter  int MAX_RETRY = DEF_MAX_RETRY,
   localparam int RC_W      = rcWidth(MAX_RETRY)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic            busy,
   output logic            req_valid,
   input  logic            req_ready,
   input  logic            resp_valid,
   input  logic            resp_ok,
   output logic            done,
   output logic            success,
   output logic            timeout_evt,
   output logic [RC_W-1:0] retry_cnt
);

   localparam int TW = timerWidth(TIMEOUT, BACKOFF);

   state_e            state_q, state_d;
   logic              busy_q;
   logic              reqValid_q;
   logic              done_q;
   logic              success_q, success_d;
   logic              timeoutEvt_q, timeoutEvt_d;
   logic [RC_W-1:0]   retryCnt_q, retryCnt_d;

   logic              timerClear;
   logic              timerEnable;
   logic [TW-1:0]     timerLimit;
   logic              timerAtLimit;
   logic              attemptFailed;

   // One timer serves both WAIT and BACKOFF; any state change restarts it.
   assign timerClear  = (state_d != state_q);
   assign timerEnable = (state_q == ST_WAIT) || (state_q == ST_BACKOFF);
   assign timerLimit  = (state_q == ST_BACKOFF) ? TW'(BACKOFF) : TW'(TIMEOUT);

   retry_timer #(
      .W (TW)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (timerClear),
      .enable_i  (timerEnable),
      .limit_i   (timerLimit),
      .atLimit_o (timerAtLimit)
   );

   // Next-state decisions. Abort outranks any response or timeout, and a
   // response on the timeout cycle outranks the timeout itself.
   always_comb begin
      state_d       = state_q;
      success_d     = success_q;
      retryCnt_d    = retryCnt_q;
      timeoutEvt_d  = 1'b0;
      attemptFailed = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_ISSUE;
               retryCnt_d = '0;
               success_d  = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (abort) begin
               state_d   = ST_DONE;
               success_d = 1'b0;
            end else if (req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_d   = ST_DONE;
               success_d = 1'b0;
            end else if (resp_valid && resp_ok) begin
               state_d   = ST_DONE;
               success_d = 1'b1;
            end else if (resp_valid) begin
               attemptFailed = 1'b1;
            end else if (timerAtLimit) begin
               attemptFailed = 1'b1;
               timeoutEvt_d  = 1'b1;
            end
         end
         ST_BACKOFF: begin
            if (abort) begin
               state_d   = ST_DONE;
               success_d = 1'b0;
            end else if (timerAtLimit) begin
               state_d = ST_ISSUE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Out of retries ends the transaction; otherwise count it and back off.
      if (attemptFailed) begin
         if (retryCnt_q == RC_W'(MAX_RETRY)) begin
            state_d   = ST_DONE;
            success_d = 1'b0;
         end else begin
            state_d    = ST_BACKOFF;
            retryCnt_d = retryCnt_q + 1'b1;
         end
      end
   end

   // All outputs are registered from the next state so they change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         reqValid_q   <= 1'b0;
         done_q       <= 1'b0;
         success_q    <= 1'b0;
         timeoutEvt_q <= 1'b0;
         retryCnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= (state_d != ST_IDLE);
         reqValid_q   <= (state_d == ST_ISSUE);
         done_q       <= (state_d == ST_DONE);
         success_q    <= success_d;
         timeoutEvt_q <= timeoutEvt_d;
         retryCnt_q   <= retryCnt_d;
      end
   end

   assign busy        = busy_q;
   assign req_valid   = reqValid_q;
   assign done        = done_q;
   assign success     = success_q;
   assign timeout_evt = timeoutEvt_q;
   assign retry_cnt   = retryCnt_q;

endmodule

// File: tb/tb_retry_ctrl.sv
// Self-checking bench for retry_ctrl: directed vector table, hand-written
// abort/reset sequences and randomized transactions against a txn-level model.
module tb_retry_ctrl;

   localparam int TMO  = 8;
   localparam int BKO  = 4;
   localparam int MAXR = 2;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       busy;
   logic       req_valid;
   logic       req_ready;
   logic       resp_valid;
   logic       resp_ok;
   logic       done;
   logic       success;
   logic       timeout_evt;
   logic [1:0] retry_cnt;

   int errors;
   int checks;
   int cyc;
   int firstDone;
   int hsCount;
   int tmoCount;
   int doneCount;
   bit noiseOn;

   int attDly [MAXR+1];
   int attIdx [MAXR+1];
   int attOk  [MAXR+1];
   int nAtt;

   typedef struct {
      int nAtt;
      int d0; int d1; int d2;
      int i0; int i1; int i2;
      int o0; int o1; int o2;
      int expSucc;
      int expRetry;
      int expHs;
      int expTmo;
      int expLat;
   } vec_t;

   vec_t vecs [6];

   retry_ctrl #(
      .TIMEOUT   (TMO),
      .BACKOFF   (BKO),
      .MAX_RETRY (MAXR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_ok     (resp_ok),
      .done        (done),
      .success     (success),
      .timeout_evt (timeout_evt),
      .retry_cnt   (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters sampled mid-cycle, well away from the rising edge.
   always @(negedge clk) begin
      if (req_valid && req_ready) hsCount++;
      if (timeout_evt) tmoCount++;
      if (done) doneCount++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (done && firstDone < 0) firstDone = cyc;
   endtask

   // Drive one transaction from the attempt arrays; returns start-to-done latency.
   task automatic applyStimulus(output int latency);
      int t0;
      int waitLen;
      firstDone = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      t0 = cyc;
      for (int a = 0; a < nAtt; a++) begin
         for (int d = 0; d <= attDly[a]; d++) begin
            req_ready  = (d == attDly[a]);
            start      = noiseOn ? 1'($urandom_range(0, 1)) : 1'b0;
            resp_valid = noiseOn ? 1'($urandom_range(0, 1)) : 1'b0;
            resp_ok    = noiseOn ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
         end
         req_ready = 1'b0;
         start     = 1'b0;
         waitLen   = (attIdx[a] > TMO) ? TMO + 1 : attIdx[a] + 1;
         for (int i = 0; i < waitLen; i++) begin
            resp_valid = (i == attIdx[a]);
            resp_ok    = (attOk[a] != 0);
            tick();
         end
         resp_valid = 1'b0;
         if (a < nAtt - 1) begin
            for (int i = 0; i <= BKO; i++) begin
               start      = noiseOn ? 1'($urandom_range(0, 1)) : 1'b0;
               resp_valid = noiseOn ? 1'($urandom_range(0, 1)) : 1'b0;
               tick();
            end
         end
         start      = 1'b0;
         resp_valid = 1'b0;
      end
      for (int k = 0; k < 20 && firstDone < 0; k++) tick();
      latency = (firstDone < 0) ? -1 : firstDone - t0;
   endtask

   task automatic runTxnCheck(input string name, input int expSucc, input int expRetry,
                              input int expHs, input int expTmo, input int expLat);
      int hs0, tmo0, done0, lat;
      hs0   = hsCount;
      tmo0  = tmoCount;
      done0 = doneCount;
      applyStimulus(lat);
      checkOutput({name, " latency"}, lat, expLat);
      checkOutput({name, " done"}, done, 1);
      checkOutput({name, " success"}, success, expSucc);
      checkOutput({name, " retry_cnt"}, retry_cnt, expRetry);
      tick();
      checkOutput({name, " done pulse width"}, done, 0);
      checkOutput({name, " idle busy"}, busy, 0);
      checkOutput({name, " success held"}, success, expSucc);
      checkOutput({name, " handshakes"}, hsCount - hs0, expHs);
      checkOutput({name, " timeouts"}, tmoCount - tmo0, expTmo);
      checkOutput({name, " done count"}, doneCount - done0, 1);
   endtask

   // Transaction-level reference: attempt outcomes summed into cycles and totals.
   task automatic model(output int n, output int succ, output int tmo, output int lat);
      n = 0; succ = 0; tmo = 0; lat = 0;
      for (int a = 0; a <= MAXR; a++) begin
         n++;
         lat += attDly[a] + 1 + ((attIdx[a] > TMO) ? TMO : attIdx[a]) + 1;
         if (attIdx[a] <= TMO && attOk[a] != 0) begin
            succ = 1;
            break;
         end
         if (attIdx[a] > TMO) tmo++;
         if (a < MAXR) lat += BKO + 1;
      end
   endtask

   task automatic loadVec(input vec_t v);
      nAtt = v.nAtt;
      attDly[0] = v.d0; attDly[1] = v.d1; attDly[2] = v.d2;
      attIdx[0] = v.i0; attIdx[1] = v.i1; attIdx[2] = v.i2;
      attOk[0]  = v.o0; attOk[1]  = v.o1; attOk[2]  = v.o2;
   endtask

   initial begin
      int n, s, t, l;
      errors = 0; checks = 0; cyc = 0; firstDone = -1;
      hsCount = 0; tmoCount = 0; doneCount = 0; noiseOn = 1'b0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_ok = 1'b0;

      //               n  dly     idx     ok      succ retry hs tmo lat
      vecs[0] = '{1, 0,0,0, 3,0,0, 1,0,0, 1, 0, 1, 0, 5};
      vecs[1] = '{3, 0,0,0, 9,9,9, 0,0,0, 0, 2, 3, 3, 40};
      vecs[2] = '{2, 1,0,0, 2,0,0, 0,1,0, 1, 1, 2, 0, 12};
      vecs[3] = '{1, 2,0,0, 8,0,0, 1,0,0, 1, 0, 1, 0, 12};
      vecs[4] = '{3, 0,0,0, 0,0,0, 0,0,0, 0, 2, 3, 0, 16};
      vecs[5] = '{3, 0,0,0, 9,8,5, 0,0,1, 1, 2, 3, 1, 37};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset outputs", int'({busy, req_valid, done, success, timeout_evt, retry_cnt}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("idle after reset", int'({busy, req_valid, done}), 0);

      for (int v = 0; v < 6; v++) begin
         loadVec(vecs[v]);
         runTxnCheck($sformatf("vec%0d", v), vecs[v].expSucc, vecs[v].expRetry,
                     vecs[v].expHs, vecs[v].expTmo, vecs[v].expLat);
      end

      // Long stall in ISSUE, timeout, then abort in BACKOFF.
      begin
         int tmo0;
         tmo0 = tmoCount;
         start = 1'b1; tick(); start = 1'b0;
         for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("stall req_valid c%0d", i), req_valid, 1);
            tick();
         end
         checkOutput("stall no timeout", tmoCount - tmo0, 0);
         req_ready = 1'b1; tick(); req_ready = 1'b0;
         checkOutput("stall wait req_valid", req_valid, 0);
         repeat (TMO + 1) tick();
         checkOutput("stall timeout pulse", timeout_evt, 1);
         checkOutput("stall retry_cnt", retry_cnt, 1);
         tick();
         checkOutput("stall timeout one cycle", timeout_evt, 0);
         abort = 1'b1; tick(); abort = 1'b0;
         checkOutput("abort backoff done", done, 1);
         checkOutput("abort backoff success", success, 0);
         checkOutput("abort backoff req_valid", req_valid, 0);
         tick();
         checkOutput("abort backoff idle", int'({busy, done}), 0);
      end

      // Abort while still requesting: req_valid drops with done.
      start = 1'b1; tick(); start = 1'b0;
      abort = 1'b1; tick(); abort = 1'b0;
      checkOutput("abort issue req_valid", req_valid, 0);
      checkOutput("abort issue done", done, 1);
      checkOutput("abort issue retry_cnt", retry_cnt, 0);
      tick();

      // Start while busy is ignored; reset mid-WAIT of the second attempt.
      begin
         int done0;
         start = 1'b1; tick(); start = 1'b0;
         req_ready = 1'b1; tick(); req_ready = 1'b0;
         start = 1'b1; resp_valid = 1'b1; resp_ok = 1'b0;
         tick();
         start = 1'b0; resp_valid = 1'b0;
         checkOutput("busy start ignored", int'({busy, req_valid}), 2);
         checkOutput("nack retry_cnt", retry_cnt, 1);
         repeat (BKO + 1) tick();
         checkOutput("reissue req_valid", req_valid, 1);
         req_ready = 1'b1; tick(); req_ready = 1'b0;
         tick(); tick();
         done0 = doneCount;
         #2;
         rst_n = 1'b0;
         #1;
         checkOutput("async reset outputs", int'({busy, req_valid, done, success, timeout_evt, retry_cnt}), 0);
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         tick();
         checkOutput("reset no done", doneCount - done0, 0);
         loadVec(vecs[0]);
         runTxnCheck("post-reset", 1, 0, 1, 0, 5);
      end

      // Randomized transactions with ignored-input noise.
      noiseOn = 1'b1;
      for (int r = 0; r < 40; r++) begin
         for (int a = 0; a <= MAXR; a++) begin
            attDly[a] = $urandom_range(0, 3);
            attIdx[a] = $urandom_range(0, TMO + 2);
            attOk[a]  = $urandom_range(0, 1);
         end
         model(n, s, t, l);
         nAtt = n;
         runTxnCheck($sformatf("rand%0d", r), s, n - 1, n, t, l);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
